riscv_div_sched: RTL

//  Shares one fixed-latency pipelined FPGA divider (signed + unsigned cores, AXI-stream style) between
//  NUM_REQ requesters. Round-robin arbitration, in-order tag pipeline and a response FIFO.

---
 rtl/riscv_div_sched_if.sv | 27 ++
 rtl/riscv_div_sched.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_div_sched_if.sv
// Requester/response bus of the shared divider scheduler.
// The master side is the EX-stage requesters plus the response consumer; the slave side is the scheduler.
interface riscv_div_sched_if #(
  parameter int NUM_REQ = 2
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [2*NUM_REQ-1:0]  req_op;
  logic [32*NUM_REQ-1:0] req_a;
  logic [32*NUM_REQ-1:0] req_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [31:0]           rsp_data;
  logic [ID_W-1:0]       rsp_id;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id
  );
endinterface

// File: rtl/riscv_div_sched.sv
// Shares one fixed-latency pipelined divider (signed + unsigned cores) between NUM_REQ requesters:
// round-robin grant, in-order tag pipe, local RISC-V corner cases and a credit-protected response FIFO.
module riscv_div_sched #(
  parameter int NUM_REQ    = 2,
  parameter int LATENCY    = 20,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  riscv_div_sched_if.slave     bus,
  output logic                 div_ss_tvalid_o,
  output logic                 div_uu_tvalid_o,
  output logic [31:0]          div_dividend_o,
  output logic [31:0]          div_divisor_o,
  output logic                 div_aresetn_o,
  input  logic                 div_dout_tvalid_i,
  input  logic [63:0]          div_dout_tdata_i,
  output logic                 busy_o,
  output logic                 err_o
);
  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 2;
  localparam logic [ID_W:0]      NUM_REQ_W = (ID_W + 1)'(NUM_REQ);
  localparam logic [CNT_W-1:0]   DEPTH_W   = CNT_W'(FIFO_DEPTH);
  localparam logic [ID_W-1:0]    LAST_REQ  = ID_W'(NUM_REQ - 1);
  localparam logic [PTR_W:0]     FIFO_FULL = (PTR_W + 1)'(FIFO_DEPTH);

  typedef struct packed {
    logic            special;
    logic            rem;
    logic [ID_W-1:0] id;
    logic [31:0]     res;
  } tag_t;

  // Per-requester views of the flattened request buses
  logic [1:0]  op_arr [NUM_REQ];
  logic [31:0] a_arr  [NUM_REQ];
  logic [31:0] b_arr  [NUM_REQ];

  // Arbitration
  logic [ID_W-1:0]      rr_ptr_reg;
  logic [ID_W-1:0]      rr_ptr_next;
  logic [2*NUM_REQ-1:0] valid_dbl;
  logic [NUM_REQ-1:0]   valid_rot;
  logic                 grant_any;
  logic [ID_W:0]        grant_off;
  logic [ID_W:0]        grant_sum;
  logic [ID_W-1:0]      grant_idx;
  logic                 credit_ok;
  logic                 grant;

  // Selected request and corner-case resolution
  logic [1:0]  sel_op;
  logic [31:0] sel_a;
  logic [31:0] sel_b;
  logic        div_zero;
  logic        div_ovf;
  logic        special;
  logic [31:0] spec_res;
  tag_t        new_tag;

  // Tag pipe
  logic             pipe_valid_reg [LATENCY];
  tag_t             pipe_tag_reg   [LATENCY];
  logic [CNT_W-1:0] pipe_cnt_reg;
  logic [CNT_W-1:0] pipe_cnt_next;
  logic             last_valid;
  tag_t             last_tag;

  // Retire
  logic            retire_push;
  logic            retire_err;
  logic [31:0]     retire_data;
  logic [ID_W-1:0] retire_id;
  logic            err_reg;

  // Response FIFO
  logic [31:0]      fifo_data_reg [FIFO_DEPTH];
  logic [ID_W-1:0]  fifo_id_reg   [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   fifo_cnt_reg;
  logic [PTR_W:0]   fifo_cnt_next;
  logic             fifo_pop;
  logic [CNT_W-1:0] inflight;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign op_arr[gi] = bus.req_op[2*gi +: 2];
      assign a_arr[gi]  = bus.req_a[32*gi +: 32];
      assign b_arr[gi]  = bus.req_b[32*gi +: 32];
      assign bus.req_ready[gi] = grant && (grant_idx == ID_W'(gi));
    end
  endgenerate

  // Rotate so bit 0 is the requester at the RR pointer; lowest set bit wins.
  assign valid_dbl = {bus.req_valid, bus.req_valid};
  assign valid_rot = NUM_REQ'(valid_dbl >> rr_ptr_reg);

  always_comb begin
    grant_any = 1'b0;
    grant_off = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (valid_rot[k]) begin
        grant_any = 1'b1;
        grant_off = (ID_W + 1)'(k);
      end
    end
  end

  assign grant_sum   = {1'b0, rr_ptr_reg} + grant_off;
  assign grant_idx   = (grant_sum >= NUM_REQ_W) ? ID_W'(grant_sum - NUM_REQ_W) : ID_W'(grant_sum);
  assign inflight    = pipe_cnt_reg + CNT_W'(fifo_cnt_reg);
  assign credit_ok   = inflight < DEPTH_W;
  assign grant       = grant_any && credit_ok && !rst;
  assign rr_ptr_next = (grant_idx == LAST_REQ) ? '0 : grant_idx + 1'b1;

  assign sel_op = op_arr[grant_idx];
  assign sel_a  = a_arr[grant_idx];
  assign sel_b  = b_arr[grant_idx];

  // Divide-by-zero and signed overflow never reach the IP; their results ride the tag pipe.
  assign div_zero = (sel_b == 32'h0000_0000);
  assign div_ovf  = !sel_op[0] && (sel_a == 32'h8000_0000) && (sel_b == 32'hFFFF_FFFF);
  assign special  = div_zero || div_ovf;

  always_comb begin
    if (div_zero) begin
      spec_res = sel_op[1] ? sel_a : 32'hFFFF_FFFF;
    end else begin
      spec_res = sel_op[1] ? 32'h0000_0000 : 32'h8000_0000;
    end
  end

  assign new_tag = '{special: special, rem: sel_op[1], id: grant_idx, res: spec_res};

  assign div_ss_tvalid_o = grant && !special && !sel_op[0];
  assign div_uu_tvalid_o = grant && !special && sel_op[0];
  assign div_dividend_o  = grant ? sel_a : 32'h0000_0000;
  assign div_divisor_o   = grant ? sel_b : 32'h0000_0000;
  assign div_aresetn_o   = !rst;

  assign last_valid    = pipe_valid_reg[LATENCY-1];
  assign last_tag      = pipe_tag_reg[LATENCY-1];
  assign pipe_cnt_next = pipe_cnt_reg + CNT_W'(grant) - CNT_W'(last_valid);

  // The IP must answer exactly when a normal tag retires and stay silent otherwise.
  always_comb begin
    retire_push = 1'b0;
    retire_err  = 1'b0;
    retire_data = last_tag.res;
    retire_id   = last_tag.id;
    if (last_valid && !last_tag.special) begin
      if (div_dout_tvalid_i) begin
        retire_push = 1'b1;
        retire_data = last_tag.rem ? div_dout_tdata_i[31:0] : div_dout_tdata_i[63:32];
      end else begin
        retire_err = 1'b1;
      end
    end else if (last_valid) begin
      if (div_dout_tvalid_i) begin
        retire_err = 1'b1;
      end else begin
        retire_push = 1'b1;
      end
    end else if (div_dout_tvalid_i) begin
      retire_err = 1'b1;
    end
  end

  assign fifo_pop = (fifo_cnt_reg != '0) && bus.rsp_ready;

  always_comb begin
    fifo_cnt_next = fifo_cnt_reg;
    if (retire_push && !fifo_pop && (fifo_cnt_reg != FIFO_FULL)) begin
      fifo_cnt_next = fifo_cnt_reg + 1'b1;
    end else if (!retire_push && fifo_pop) begin
      fifo_cnt_next = fifo_cnt_reg - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_reg   <= '0;
      pipe_cnt_reg <= '0;
      err_reg      <= 1'b0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      fifo_cnt_reg <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        pipe_valid_reg[i] <= 1'b0;
      end
    end else begin
      if (grant) begin
        rr_ptr_reg <= rr_ptr_next;
      end
      pipe_cnt_reg      <= pipe_cnt_next;
      pipe_valid_reg[0] <= grant;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_valid_reg[i] <= pipe_valid_reg[i-1];
      end
      if (retire_err) begin
        err_reg <= 1'b1;
      end
      if (retire_push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (fifo_pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      fifo_cnt_reg <= fifo_cnt_next;
    end
  end

  // Payload storage carries no reset; validity lives in the registers above.
  always_ff @(posedge clk) begin
    pipe_tag_reg[0] <= new_tag;
    for (int i = 1; i < LATENCY; i++) begin
      pipe_tag_reg[i] <= pipe_tag_reg[i-1];
    end
    if (retire_push) begin
      fifo_data_reg[wr_ptr_reg] <= retire_data;
      fifo_id_reg[wr_ptr_reg]   <= retire_id;
    end
  end

  assign bus.rsp_valid = !rst && (fifo_cnt_reg != '0);
  assign bus.rsp_data  = bus.rsp_valid ? fifo_data_reg[rd_ptr_reg] : 32'h0000_0000;
  assign bus.rsp_id    = bus.rsp_valid ? fifo_id_reg[rd_ptr_reg] : '0;
  assign busy_o        = !rst && (inflight != '0);
  assign err_o         = !rst && err_reg;
endmodule
